command_issuer: RTL and testbench

COMMAND_ISSUER -- requirements
Module: command_issuer

---
 rtl/cmd_pkg.sv | 49 ++++
 rtl/cmd_byte_serializer.sv | 49 ++++
 rtl/command_issuer.sv | 176 +++++++++++++++++
 tb/tb_command_issuer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : cmd_pkg                                                         |
// | Purpose : Shared definitions for the command issuer. Holds the FSM state  |
// |           encoding, the opcode values, the positions of fields inside     |
// |           the 64-bit command word, and small helper functions.            |
// | Ports   : none (package)                                                  |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package cmd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_TX_CMD   = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   localparam logic [7:0] OP_STREAM    = 8'h00;
   localparam logic [7:0] OP_CLKSWITCH = 8'h01;
   localparam logic [7:0] OP_VERSION   = 8'h02;

   // Byte positions inside the 64-bit command word.
   localparam int         CMD_BYTES    = 8;
   localparam logic [2:0] BYTE_OPCODE  = 3'd0;
   localparam logic [2:0] BYTE_LEN_LSB = 3'd4;
   localparam logic [2:0] BYTE_LEN_MSB = 3'd7;
   localparam logic [2:0] BYTE_LAST    = 3'(CMD_BYTES - 1);

   function automatic logic [2:0] popcount4(input logic [3:0] keep);
      return {2'b00, keep[0]} + {2'b00, keep[1]} + {2'b00, keep[2]} + {2'b00, keep[3]};
   endfunction

   function automatic logic expects_response(input logic [7:0] op);
      return (op == OP_STREAM) || (op == OP_CLKSWITCH) || (op == OP_VERSION);
   endfunction

   // Only meaningful when expects_response(op) is true.
   function automatic logic [31:0] expected_bytes(input logic [7:0] op, input logic [31:0] len);
      return (op == OP_STREAM) ? len : 32'd4;
   endfunction

   // Reference word for stream data: bytes x-4..x-1, x-4 in the top byte.
   function automatic logic [31:0] pattern_word(input logic [7:0] x);
      return {x - 8'd4, x - 8'd3, x - 8'd2, x - 8'd1};
   endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_byte_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cmd_byte_serializer                                             |
// | Purpose : Latches a 64-bit command and presents it byte 0 first on an     |
// |           8-bit AXI-stream master. The byte index only moves on a         |
// |           completed handshake, so data holds steady while stalled.        |
// | Ports   : clk, rst            clock / synchronous active-high reset       |
// |           load, cmd_data      capture a new command, restart at byte 0    |
// |           enable              high while the command is being sent        |
// |           tvalid/tready/tdata byte stream master                          |
// |           last_accepted       pulse when the final byte is taken          |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module cmd_byte_serializer
   import cmd_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [63:0] cmd_data,
   input  logic        enable,
   output logic        tvalid,
   input  logic        tready,
   output logic [7:0]  tdata,
   output logic        last_accepted
);

   logic [63:0] cmd_word;
   logic [2:0]  byte_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_word <= 64'd0;
         byte_idx <= BYTE_OPCODE;
      end else if (load) begin
         cmd_word <= cmd_data;
         byte_idx <= BYTE_OPCODE;
      end else if (enable && tready) begin
         byte_idx <= byte_idx + 3'd1;
      end
   end

   assign tvalid        = enable;
   // Drive zero outside the send window so the bus is quiet when idle.
   assign tdata         = enable ? cmd_word[{byte_idx, 3'b000} +: 8] : 8'h00;
   assign last_accepted = enable && tready && (byte_idx == BYTE_LAST);

endmodule
`default_nettype wire

// File: rtl/command_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : command_issuer                                                  |
// | Purpose : Accepts a 64-bit command, sends it as 8 bytes, then collects    |
// |           the 32-bit response stream, counting enabled bytes and          |
// |           flagging timeout / length (and optionally pattern) errors.      |
// | Config  : CMD_PATTERN_CHECK_EN - when defined, opcode-0 response data is  |
// |           compared against the reference pattern (err_pattern).          |
// | Ports   : clk, rst                          clock / sync active-high rst  |
// |           cmd_valid, cmd_ready, cmd_data    command input handshake       |
// |           o_tvalid, o_tready, o_tdata       command byte stream (master)  |
// |           i_tvalid, i_tready, i_tdata,                                    |
// |           i_tkeep, i_tlast                  response stream (slave)       |
// |           rsp_valid, rsp_first_word,                                      |
// |           rsp_byte_count                    transaction result            |
// |           err_timeout, err_length,                                        |
// |           err_pattern                       error flags                   |
// |           busy                              high whenever not idle        |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module command_issuer
   import cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [63:0] cmd_data,
   output logic        o_tvalid,
   input  logic        o_tready,
   output logic [7:0]  o_tdata,
   input  logic        i_tvalid,
   output logic        i_tready,
   input  logic [31:0] i_tdata,
   input  logic [3:0]  i_tkeep,
   input  logic        i_tlast,
   output logic        rsp_valid,
   output logic [31:0] rsp_first_word,
   output logic [31:0] rsp_byte_count,
   output logic        err_timeout,
   output logic        err_length,
   output logic        err_pattern,
   output logic        busy
);

   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t      state, state_next;
   logic [7:0]  opcode;
   logic [31:0] cmd_len;
   logic [31:0] byte_count;
   logic [31:0] first_word;
   logic [31:0] tmo_count;
   logic        seen_beat;

   logic        cmd_fire;
   logic        beat;
   logic        ser_last;
   logic        tmo_expired;
   logic [32:0] count_sum;
   logic [31:0] count_next;

   assign cmd_ready = (state == ST_IDLE);
   assign i_tready  = (state == ST_WAIT_RSP);
   assign busy      = (state != ST_IDLE);
   assign rsp_valid = (state == ST_DONE);
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign beat      = i_tvalid && (state == ST_WAIT_RSP);

   cmd_byte_serializer u_ser (
      .clk           (clk),
      .rst           (rst),
      .load          (cmd_fire),
      .cmd_data      (cmd_data),
      .enable        (state == ST_TX_CMD),
      .tvalid        (o_tvalid),
      .tready        (o_tready),
      .tdata         (o_tdata),
      .last_accepted (ser_last)
   );

   // Saturating byte accumulator; count_next is the value after this cycle.
   assign count_sum  = {1'b0, byte_count} + {30'd0, popcount4(i_tkeep)};
   assign count_next = !beat        ? byte_count :
                       count_sum[32] ? 32'hFFFF_FFFF : count_sum[31:0];

   // The counter reaches TIMEOUT_CYCLES on the same edge that enters DONE.
   assign tmo_expired = (state == ST_WAIT_RSP) && !beat && (tmo_count == TMO_LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:     if (cmd_fire) state_next = ST_TX_CMD;
         ST_TX_CMD:   if (ser_last) state_next = expects_response(opcode) ? ST_WAIT_RSP : ST_DONE;
         ST_WAIT_RSP: if ((beat && i_tlast) || tmo_expired) state_next = ST_DONE;
         ST_DONE:     state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opcode      <= 8'd0;
         cmd_len     <= 32'd0;
         byte_count  <= 32'd0;
         first_word  <= 32'd0;
         tmo_count   <= 32'd0;
         seen_beat   <= 1'b0;
         err_timeout <= 1'b0;
         err_length  <= 1'b0;
      end else begin
         // Results stay visible until the next command is taken.
         if (cmd_fire) begin
            opcode      <= cmd_data[7:0];
            cmd_len     <= cmd_data[63:32];
            byte_count  <= 32'd0;
            first_word  <= 32'd0;
            seen_beat   <= 1'b0;
            err_timeout <= 1'b0;
            err_length  <= 1'b0;
         end

         if (state != ST_WAIT_RSP || beat) tmo_count <= 32'd0;
         else                              tmo_count <= tmo_count + 32'd1;

         if (beat) begin
            byte_count <= count_next;
            seen_beat  <= 1'b1;
            if (!seen_beat) first_word <= i_tdata;
         end

         if (state == ST_WAIT_RSP && state_next == ST_DONE) begin
            err_timeout <= tmo_expired;
            err_length  <= (count_next != expected_bytes(opcode, cmd_len));
         end
      end
   end

   assign rsp_first_word = first_word;
   assign rsp_byte_count = byte_count;

`ifdef CMD_PATTERN_CHECK_EN
   // Beats 0 and 1 both use L; each later beat steps the base down by 4.
   logic [7:0]  pat_base;
   logic        pat_err;
   logic [31:0] pat_mask;

   assign pat_mask = {{8{i_tkeep[3]}}, {8{i_tkeep[2]}}, {8{i_tkeep[1]}}, {8{i_tkeep[0]}}};

   always_ff @(posedge clk) begin
      if (rst) begin
         pat_base <= 8'd0;
         pat_err  <= 1'b0;
      end else if (cmd_fire) begin
         pat_base <= cmd_data[39:32];
         pat_err  <= 1'b0;
      end else if (beat && opcode == OP_STREAM) begin
         if (|((i_tdata ^ pattern_word(pat_base)) & pat_mask)) pat_err <= 1'b1;
         if (seen_beat) pat_base <= pat_base - 8'd4;
      end
   end

   assign err_pattern = pat_err;
`else
   assign err_pattern = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_command_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_command_issuer                                               |
// | Purpose : Self-checking bench for command_issuer. Table of directed       |
// |           transactions plus hand-written timeout and reset sequences.     |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_command_issuer;

   localparam int TMO = 16;
`ifdef CMD_PATTERN_CHECK_EN
   localparam bit PAT_EN = 1'b1;
`else
   localparam bit PAT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [63:0] cmd_data = 64'd0;
   logic        o_tvalid;
   logic        o_tready = 1'b0;
   logic [7:0]  o_tdata;
   logic        i_tvalid = 1'b0;
   logic        i_tready;
   logic [31:0] i_tdata = 32'd0;
   logic [3:0]  i_tkeep = 4'd0;
   logic        i_tlast = 1'b0;
   logic        rsp_valid;
   logic [31:0] rsp_first_word;
   logic [31:0] rsp_byte_count;
   logic        err_timeout, err_length, err_pattern, busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   command_issuer #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
      .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tdata(o_tdata),
      .i_tvalid(i_tvalid), .i_tready(i_tready), .i_tdata(i_tdata),
      .i_tkeep(i_tkeep), .i_tlast(i_tlast),
      .rsp_valid(rsp_valid), .rsp_first_word(rsp_first_word),
      .rsp_byte_count(rsp_byte_count), .err_timeout(err_timeout),
      .err_length(err_length), .err_pattern(err_pattern), .busy(busy)
   );

   typedef struct {
      logic [7:0]       op;
      logic [23:0]      fill;
      logic [31:0]      len;
      bit               toggle;
      bit               junk;
      int               nbeats;
      logic [2:0][31:0] data;
      logic [2:0][3:0]  keep;
      logic [31:0]      exp_first;
      logic [31:0]      exp_count;
      bit               exp_len;
      bit               exp_pat;
   } vec_t;

   vec_t vecs[8];

   function automatic vec_t mk(input logic [7:0] op, input logic [23:0] fill, input logic [31:0] len,
                               input bit toggle, input bit junk, input int nbeats,
                               input logic [31:0] d0, input logic [3:0] k0,
                               input logic [31:0] d1, input logic [3:0] k1,
                               input logic [31:0] d2, input logic [3:0] k2,
                               input logic [31:0] ef, input logic [31:0] ec,
                               input bit el, input bit ep);
      vec_t v;
      v.op = op; v.fill = fill; v.len = len; v.toggle = toggle; v.junk = junk;
      v.nbeats = nbeats;
      v.data[0] = d0; v.data[1] = d1; v.data[2] = d2;
      v.keep[0] = k0; v.keep[1] = k1; v.keep[2] = k2;
      v.exp_first = ef; v.exp_count = ec; v.exp_len = el; v.exp_pat = ep;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cmd_ready();
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (cmd_ready !== 1'b1) check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
   endtask

   // Handshakes a command and takes all 8 bytes, checking order and hold.
   // Returns at the negedge following the final byte acceptance.
   task automatic send_cmd(input logic [63:0] word, input bit toggle, input bit junk);
      int nacc = 0;
      int cyc  = 0;
      bit stalled_prev = 1'b0;
      logic [7:0] prev = 8'd0;
      logic ready;
      wait_cmd_ready();
      cmd_valid = 1'b1;
      cmd_data  = word;
      if (junk) begin
         i_tvalid = 1'b1; i_tdata = 32'hDEADBEEF; i_tkeep = 4'hF; i_tlast = 1'b1;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      check("busy_tx", 64'(busy), 64'd1);
      while (nacc < 8 && cyc < 64) begin
         ready = toggle ? cyc[0] : 1'b1;
         o_tready = ready;
         check("o_tvalid_tx", 64'(o_tvalid), 64'd1);
         if (stalled_prev) check("o_tdata_hold", 64'(o_tdata), 64'(prev));
         if (ready) begin
            check($sformatf("o_tdata_byte%0d", nacc), 64'(o_tdata), 64'(word[8*nacc +: 8]));
            nacc++;
         end
         stalled_prev = !ready;
         prev = o_tdata;
         cyc++;
         @(negedge clk);
      end
      o_tready = 1'b0;
      i_tvalid = 1'b0; i_tlast = 1'b0; i_tkeep = 4'd0; i_tdata = 32'd0;
      if (nacc < 8) check("tx_bytes_taken", 64'(nacc), 64'd8);
   endtask

   task automatic run_txn(input vec_t v, input int id);
      bit has_rsp = (v.op <= 8'd2);
      send_cmd({v.len, v.fill, v.op}, v.toggle, v.junk);
      if (has_rsp) begin
         check($sformatf("v%0d_i_tready", id), 64'(i_tready), 64'd1);
         for (int b = 0; b < v.nbeats; b++) begin
            i_tvalid = 1'b1;
            i_tdata  = v.data[b];
            i_tkeep  = v.keep[b];
            i_tlast  = (b == v.nbeats - 1);
            @(negedge clk);
         end
         i_tvalid = 1'b0; i_tlast = 1'b0;
      end
      check($sformatf("v%0d_rsp_valid", id), 64'(rsp_valid), 64'd1);
      check($sformatf("v%0d_first_word", id), 64'(rsp_first_word), 64'(v.exp_first));
      check($sformatf("v%0d_byte_count", id), 64'(rsp_byte_count), 64'(v.exp_count));
      check($sformatf("v%0d_err_length", id), 64'(err_length), 64'(v.exp_len));
      check($sformatf("v%0d_err_pattern", id), 64'(err_pattern), 64'(v.exp_pat));
      check($sformatf("v%0d_err_timeout", id), 64'(err_timeout), 64'd0);
      @(negedge clk);
      check($sformatf("v%0d_rsp_pulse_end", id), 64'(rsp_valid), 64'd0);
      check($sformatf("v%0d_idle_ready", id), 64'(cmd_ready), 64'd1);
      check($sformatf("v%0d_count_held", id), 64'(rsp_byte_count), 64'(v.exp_count));
      check($sformatf("v%0d_len_held", id), 64'(err_length), 64'(v.exp_len));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int seen;
      //           op     fill       len            tog junk nb  d0            k0    d1            k1    d2            k2    first         count  el  ep
      vecs[0] = mk(8'h02, 24'h0,     32'd0,         0,  0,   2,  32'h00000002, 4'hF, 32'h0,        4'h0, 32'h0,        4'h0, 32'h00000002, 32'd4, 0,  0);
      vecs[1] = mk(8'h00, 24'h0,     32'd6,         0,  0,   2,  32'h02030405, 4'hF, 32'h02030405, 4'h3, 32'h0,        4'h0, 32'h02030405, 32'd6, 0,  0);
      vecs[2] = mk(8'h00, 24'h0,     32'd8,         0,  0,   2,  32'h04050607, 4'hF, 32'h00000000, 4'hF, 32'h0,        4'h0, 32'h04050607, 32'd8, 0,  PAT_EN);
      vecs[3] = mk(8'h00, 24'h0,     32'd12,        0,  1,   3,  32'h08090A0B, 4'hF, 32'h08090A0B, 4'hF, 32'h04050607, 4'hF, 32'h08090A0B, 32'd12, 0, 0);
      vecs[4] = mk(8'h00, 24'h332211, 32'h00000104, 0,  0,   1,  32'h00010203, 4'hF, 32'h0,        4'h0, 32'h0,        4'h0, 32'h00010203, 32'd4, 1,  0);
      vecs[5] = mk(8'h09, 24'hC0B0A0, 32'h44332211, 1,  0,   0,  32'h0,        4'h0, 32'h0,        4'h0, 32'h0,        4'h0, 32'h0,        32'd0, 0,  0);
      vecs[6] = mk(8'h01, 24'h0,     32'd0,         1,  0,   1,  32'hAABBCC00, 4'h7, 32'h0,        4'h0, 32'h0,        4'h0, 32'hAABBCC00, 32'd3, 1,  0);
      vecs[7] = mk(8'h00, 24'h0,     32'd2,         0,  0,   2,  32'hFFFFFFFF, 4'h0, 32'h12340001, 4'h3, 32'h0,        4'h0, 32'hFFFFFFFF, 32'd2, 0,  0);

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_o_tvalid", 64'(o_tvalid), 64'd0);
      check("rst_i_tready", 64'(i_tready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_o_tdata", 64'(o_tdata), 64'd0);
      check("rst_first_word", 64'(rsp_first_word), 64'd0);
      check("rst_byte_count", 64'(rsp_byte_count), 64'd0);
      check("rst_errors", 64'({err_timeout, err_length, err_pattern}), 64'd0);

      for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

      // Timeout: opcode 1, responder silent
      send_cmd({32'd0, 24'd0, 8'h01}, 1'b0, 1'b0);
      check("tmo_wait_entry", 64'(i_tready), 64'd1);
      n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("tmo_latency", 64'(n), 64'(TMO));
      check("tmo_err_timeout", 64'(err_timeout), 64'd1);
      check("tmo_err_length", 64'(err_length), 64'd1);
      check("tmo_byte_count", 64'(rsp_byte_count), 64'd0);
      @(negedge clk);
      check("tmo_rsp_pulse_end", 64'(rsp_valid), 64'd0);

      // Reset after three command bytes
      wait_cmd_ready();
      cmd_valid = 1'b1;
      cmd_data  = {32'd0, 24'hABCDEF, 8'h02};
      @(negedge clk);
      cmd_valid = 1'b0;
      o_tready  = 1'b1;
      repeat (3) @(negedge clk);
      o_tready = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_o_tvalid", 64'(o_tvalid), 64'd0);
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (rsp_valid === 1'b1) seen++;
         @(negedge clk);
      end
      check("mid_rst_no_rsp_valid", 64'(seen), 64'd0);
      run_txn(vecs[0], 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
